// File: rtl/pipeline_stall_flush_ctrl.sv
// Pipeline stall/flush sequencer: converts hazard and data-memory handshake signals into
// per-stage enable/flush controls, plus saturating stall/flush counters and a sticky timeout.
module pipeline_stall_flush_ctrl #(
  parameter int BR_SHADOW   = 1,
  parameter int MEM_TIMEOUT = 255,
  parameter int NB_CNT      = 32
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_load_hazard,
  input  logic              i_branch_hazard,
  input  logic              i_mem_req,
  input  logic              i_dmem_ready,
  output logic              o_pc_en,
  output logic              o_if_id_en,
  output logic              o_if_id_flush,
  output logic              o_id_ex_en,
  output logic              o_id_ex_flush,
  output logic              o_ex_mem_en,
  output logic              o_mem_wb_flush,
  output logic [NB_CNT-1:0] o_stall_cnt,
  output logic [NB_CNT-1:0] o_flush_cnt,
  output logic              o_mem_timeout
);

  localparam int          WAIT_W    = $clog2(MEM_TIMEOUT + 1);
  localparam logic [2:0]  SHADOW_LD = 3'(BR_SHADOW);

  typedef enum logic [1:0] {
    ST_RUN,
    ST_MEM_WAIT,
    ST_BR_SHADOW
  } state_t;

  state_t              r_state, w_state_nxt;
  logic [2:0]          r_shadow_cnt, w_shadow_cnt_nxt;
  logic [WAIT_W-1:0]   r_wait_cnt;
  logic                r_guard;
  logic                r_timeout;
  logic [NB_CNT-1:0]   r_stall_cnt;
  logic [NB_CNT-1:0]   r_flush_cnt;

  logic w_mem_stall;
  logic w_branch_take;
  logic w_load_stall;
  logic w_timeout_hit;

  assign w_mem_stall   = i_mem_req & ~i_dmem_ready;
  // The MEM_TIMEOUT-th consecutive wait cycle already reports the timeout in that same cycle.
  assign w_timeout_hit = w_mem_stall && (r_wait_cnt >= WAIT_W'(MEM_TIMEOUT - 1));

  // NOTE: every signal driven here gets a default first, so no path leaves one unassigned (no latch).
  always_comb begin
    o_pc_en          = 1'b1;
    o_if_id_en       = 1'b1;
    o_if_id_flush    = 1'b0;
    o_id_ex_en       = 1'b1;
    o_id_ex_flush    = 1'b0;
    o_ex_mem_en      = 1'b1;
    o_mem_wb_flush   = 1'b0;
    w_state_nxt      = ST_RUN;
    w_shadow_cnt_nxt = r_shadow_cnt;
    w_branch_take    = 1'b0;
    w_load_stall     = 1'b0;

    if (!i_rst_n) begin
      o_pc_en        = 1'b0;
      o_if_id_en     = 1'b0;
      o_if_id_flush  = 1'b1;
      o_id_ex_en     = 1'b0;
      o_id_ex_flush  = 1'b1;
      o_ex_mem_en    = 1'b0;
      o_mem_wb_flush = 1'b1;
    end else if (w_mem_stall) begin
      // Whole front end freezes; branch/load stay pending on their inputs until release.
      o_pc_en          = 1'b0;
      o_if_id_en       = 1'b0;
      o_id_ex_en       = 1'b0;
      o_ex_mem_en      = 1'b0;
      o_mem_wb_flush   = 1'b1;
      w_state_nxt      = ST_MEM_WAIT;
      w_shadow_cnt_nxt = 3'd0;
    end else if (i_branch_hazard) begin
      o_if_id_flush = 1'b1;
      o_id_ex_flush = 1'b1;
      w_branch_take = 1'b1;
      if (BR_SHADOW > 0) begin
        w_state_nxt      = ST_BR_SHADOW;
        w_shadow_cnt_nxt = SHADOW_LD;
      end
    end else if (r_state == ST_BR_SHADOW) begin
      o_if_id_flush = 1'b1;
      if (r_shadow_cnt <= 3'd1) begin
        w_shadow_cnt_nxt = 3'd0;
      end else begin
        w_state_nxt      = ST_BR_SHADOW;
        w_shadow_cnt_nxt = r_shadow_cnt - 3'd1;
      end
    end else if (i_load_hazard && !r_guard) begin
      o_pc_en       = 1'b0;
      o_if_id_en    = 1'b0;
      o_id_ex_flush = 1'b1;
      w_load_stall  = 1'b1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  // NOTE: only control/counter flops exist here, so all of them take the asynchronous reset.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state      <= ST_RUN;
      r_shadow_cnt <= 3'd0;
      r_wait_cnt   <= '0;
      r_guard      <= 1'b0;
      r_timeout    <= 1'b0;
      r_stall_cnt  <= '0;
      r_flush_cnt  <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_shadow_cnt <= w_shadow_cnt_nxt;

      if (w_mem_stall) begin
        if (r_wait_cnt != WAIT_W'(MEM_TIMEOUT)) r_wait_cnt <= r_wait_cnt + 1'b1;
      end else begin
        r_wait_cnt <= '0;
      end

      if (w_timeout_hit) r_timeout <= 1'b1;

      // Guard marks that the current load-use pair has already had its bubble.
      if (w_load_stall)  r_guard <= 1'b1;
      else if (o_pc_en)  r_guard <= 1'b0;

      if (!o_pc_en && (r_stall_cnt != '1)) r_stall_cnt <= r_stall_cnt + 1'b1;
      if (w_branch_take && (r_flush_cnt != '1)) r_flush_cnt <= r_flush_cnt + 1'b1;
    end
  end

  assign o_stall_cnt   = r_stall_cnt;
  assign o_flush_cnt   = r_flush_cnt;
  assign o_mem_timeout = r_timeout | (w_timeout_hit & i_rst_n);

endmodule

// File: tb/tb_pipeline_stall_flush_ctrl.sv
// Directed scoreboard bench for pipeline_stall_flush_ctrl (BR_SHADOW=2, MEM_TIMEOUT=4, NB_CNT=8).
module tb_pipeline_stall_flush_ctrl;

  localparam int NB = 8;
  localparam int TO = 4;
  localparam int SH = 2;
  localparam int SAT = (1 << NB) - 1;

  // {pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush, ex_mem_en, mem_wb_flush}
  localparam logic [6:0] C_RUN  = 7'b1101010;
  localparam logic [6:0] C_RST  = 7'b0010101;
  localparam logic [6:0] C_LOAD = 7'b0001110;
  localparam logic [6:0] C_BR   = 7'b1111110;
  localparam logic [6:0] C_SHD  = 7'b1111010;
  localparam logic [6:0] C_MEMW = 7'b0000001;

  // {load, branch, mem_req, dmem_ready}
  localparam logic [3:0] I_IDLE = 4'b0000;
  localparam logic [3:0] I_LD   = 4'b1000;
  localparam logic [3:0] I_BR   = 4'b0100;
  localparam logic [3:0] I_BRLD = 4'b1100;
  localparam logic [3:0] I_WAIT = 4'b0010;
  localparam logic [3:0] I_RDY  = 4'b0011;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic load_hz = 1'b0, branch_hz = 1'b0, mem_req = 1'b0, dmem_ready = 1'b0;
  logic pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush, ex_mem_en, mem_wb_flush;
  logic [NB-1:0] stall_cnt, flush_cnt;
  logic mem_timeout;

  always #5 clk = ~clk;

  pipeline_stall_flush_ctrl #(.BR_SHADOW(SH), .MEM_TIMEOUT(TO), .NB_CNT(NB)) dut (
    .i_clk          (clk),
    .i_rst_n        (rst_n),
    .i_load_hazard  (load_hz),
    .i_branch_hazard(branch_hz),
    .i_mem_req      (mem_req),
    .i_dmem_ready   (dmem_ready),
    .o_pc_en        (pc_en),
    .o_if_id_en     (if_id_en),
    .o_if_id_flush  (if_id_flush),
    .o_id_ex_en     (id_ex_en),
    .o_id_ex_flush  (id_ex_flush),
    .o_ex_mem_en    (ex_mem_en),
    .o_mem_wb_flush (mem_wb_flush),
    .o_stall_cnt    (stall_cnt),
    .o_flush_cnt    (flush_cnt),
    .o_mem_timeout  (mem_timeout)
  );

  typedef struct {
    string         tag;
    logic [6:0]    ctrl;
    logic [NB-1:0] stall;
    logic [NB-1:0] flush;
    logic          to;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   m_stall = 0, m_flush = 0, m_wait = 0;
  logic m_to = 1'b0;

  // One clock: drive inputs, queue the expected response, then compare it mid-cycle.
  task automatic step(input string tag, input logic rst, input logic [3:0] in,
                      input logic [6:0] exp_ctrl);
    exp_t e;
    exp_t o;
    logic [6:0] obs;
    @(posedge clk); #1;
    rst_n = rst;
    {load_hz, branch_hz, mem_req, dmem_ready} = in;
    if (!rst) begin
      m_stall = 0; m_flush = 0; m_wait = 0; m_to = 1'b0;
    end else if (exp_ctrl == C_MEMW) begin
      m_wait++;
      if (m_wait >= TO) m_to = 1'b1;
    end else begin
      m_wait = 0;
    end
    e.tag = tag; e.ctrl = exp_ctrl; e.stall = NB'(m_stall); e.flush = NB'(m_flush); e.to = m_to;
    sb.push_back(e);
    @(negedge clk);
    o = sb.pop_front();
    obs = {pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush, ex_mem_en, mem_wb_flush};
    checks++;
    assert (obs === o.ctrl) else begin
      errors++; $error("FAIL %s ctrl got %b exp %b", o.tag, obs, o.ctrl);
    end
    checks++;
    assert (stall_cnt === o.stall) else begin
      errors++; $error("FAIL %s stall_cnt got %0d exp %0d", o.tag, stall_cnt, o.stall);
    end
    checks++;
    assert (flush_cnt === o.flush) else begin
      errors++; $error("FAIL %s flush_cnt got %0d exp %0d", o.tag, flush_cnt, o.flush);
    end
    checks++;
    assert (mem_timeout === o.to) else begin
      errors++; $error("FAIL %s mem_timeout got %b exp %b", o.tag, mem_timeout, o.to);
    end
    if (rst) begin
      if (!exp_ctrl[6] && m_stall < SAT) m_stall++;
      if (exp_ctrl == C_BR && m_flush < SAT) m_flush++;
    end
  endtask

  initial begin
    // Reset holds every stage regardless of inputs.
    step("rst_all1", 1'b0, 4'b1111, C_RST);
    step("rst_all0", 1'b0, I_IDLE,  C_RST);
    step("idle",     1'b1, I_IDLE,  C_RUN);

    // One-bubble load stall with guard.
    step("load_c0",  1'b1, I_LD,   C_LOAD);
    step("load_c1",  1'b1, I_LD,   C_RUN);
    step("idle_l",   1'b1, I_IDLE, C_RUN);

    // Taken branch plus two-cycle shadow.
    step("br_c0",    1'b1, I_BR,   C_BR);
    step("br_shd1",  1'b1, I_IDLE, C_SHD);
    step("br_shd2",  1'b1, I_IDLE, C_SHD);
    step("br_done",  1'b1, I_IDLE, C_RUN);

    // Short memory wait, below timeout.
    for (int i = 0; i < 3; i++) step("mw3", 1'b1, I_WAIT, C_MEMW);
    step("mw3_rdy",  1'b1, I_RDY,  C_RUN);

    // Long memory wait trips the sticky timeout.
    for (int i = 0; i < 6; i++) step("mw6", 1'b1, I_WAIT, C_MEMW);
    step("mw6_rdy",  1'b1, I_RDY,  C_RUN);
    step("to_stick", 1'b1, I_IDLE, C_RUN);

    // Branch beats load; load during shadow ignored.
    step("brld",     1'b1, I_BRLD, C_BR);
    step("shd_ld",   1'b1, I_LD,   C_SHD);
    step("shd2",     1'b1, I_IDLE, C_SHD);
    step("brld_end", 1'b1, I_IDLE, C_RUN);

    // Branch held during memory wait is serviced on release.
    step("mw_br0",   1'b1, 4'b0110, C_MEMW);
    step("mw_br1",   1'b1, 4'b0110, C_MEMW);
    step("mw_brrdy", 1'b1, 4'b0111, C_BR);
    step("mwbr_s1",  1'b1, I_IDLE,  C_SHD);
    step("mwbr_s2",  1'b1, I_IDLE,  C_SHD);
    step("mwbr_end", 1'b1, I_IDLE,  C_RUN);

    // Load held during memory wait is serviced on release.
    step("mw_ld0",   1'b1, 4'b1010, C_MEMW);
    step("mw_ldrdy", 1'b1, 4'b1011, C_LOAD);
    step("mw_ldgd",  1'b1, I_LD,    C_RUN);

    // Branch in shadow reloads the shadow count.
    step("rb_c0",    1'b1, I_BR,   C_BR);
    step("rb_c1",    1'b1, I_BR,   C_BR);
    step("rb_s1",    1'b1, I_IDLE, C_SHD);
    step("rb_s2",    1'b1, I_IDLE, C_SHD);
    step("rb_end",   1'b1, I_IDLE, C_RUN);

    // Reset in the middle of a shadow.
    step("rs_br",    1'b1, I_BR,   C_BR);
    step("rs_rst",   1'b0, I_IDLE, C_RST);
    step("rs_idle",  1'b1, I_IDLE, C_RUN);
    step("rs_idle2", 1'b1, I_IDLE, C_RUN);

    // Stall counter saturates at all-ones.
    for (int i = 0; i < SAT + 5; i++) step("sat_mw", 1'b1, I_WAIT, C_MEMW);
    step("sat_rdy",  1'b1, I_RDY,  C_RUN);
    step("sat_ld",   1'b1, I_LD,   C_LOAD);
    step("sat_end",  1'b1, I_IDLE, C_RUN);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
